// File: rtl/mc_controller.sv
// Multi-cycle MIPS control unit: sequences FETCH/DECODE/EXEC/MEM/WB and drives datapath strobes.
// Optional MC_ILLEGAL_TRAP_EN: unrecognised non-zero words park the FSM in HALT until reset.
module mc_controller (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Instruction,
    output logic        PcWrite,
    output logic        IrWrite,
    output logic        Extop,
    output logic        ALUSrc,
    output logic [2:0]  ALUControl,
    output logic        RegDst,
    output logic        RegWrite,
    output logic        MemtoReg,
    output logic        MemWrite,
    output logic        lb_sel,
    output logic        sb_sel,
    output logic        jal_sel,
    output logic [2:0]  Npc_op,
    output logic [2:0]  state_o
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
`ifdef MC_ILLEGAL_TRAP_EN
        , S_HALT = 3'd5
`endif
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       ir_write;
        logic       ext_op;
        logic       alu_src;
        logic [2:0] alu_ctrl;
        logic       reg_dst;
        logic       reg_write;
        logic       mem_to_reg;
        logic       mem_write;
        logic       lb_sel;
        logic       sb_sel;
        logic       jal_sel;
        logic [2:0] npc_op;
    } ctrl_t;

    state_t state_q, state_d;
    ctrl_t  ctrl;

    logic [5:0] opcode;
    logic [5:0] funct;
    logic       is_rtype;
    logic       is_addu, is_subu, is_jr, is_ori, is_lui;
    logic       is_lw, is_lb, is_sw, is_sb, is_beq, is_j, is_jal;
    logic       is_alu_r, is_imm, is_load, is_store, is_known;
    logic       unused_instr_bits;

    assign opcode   = Instruction[31:26];
    assign funct    = Instruction[5:0];
    assign is_rtype = (opcode == 6'b000000);
    assign is_addu  = is_rtype && (funct == 6'b100001);
    assign is_subu  = is_rtype && (funct == 6'b100011);
    assign is_jr    = is_rtype && (funct == 6'b001000);
    assign is_ori   = (opcode == 6'b001101);
    assign is_lui   = (opcode == 6'b001111);
    assign is_lw    = (opcode == 6'b100011);
    assign is_lb    = (opcode == 6'b100000);
    assign is_sw    = (opcode == 6'b101011);
    assign is_sb    = (opcode == 6'b101000);
    assign is_beq   = (opcode == 6'b000100);
    assign is_j     = (opcode == 6'b000010);
    assign is_jal   = (opcode == 6'b000011);

    assign is_alu_r = is_addu | is_subu;
    assign is_imm   = is_ori | is_lui;
    assign is_load  = is_lw | is_lb;
    assign is_store = is_sw | is_sb;
    assign is_known = is_alu_r | is_imm | is_load | is_store | is_beq | is_j | is_jal | is_jr;

    // Register and shamt fields belong to the datapath; only opcode/funct steer control.
    assign unused_instr_bits = ^Instruction[25:6];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        ctrl    = '0;
        state_d = state_q;
        case (state_q)
            S_FETCH: begin
                ctrl.ir_write = 1'b1;
                state_d       = S_DECODE;
            end
            S_DECODE: begin
                if (is_known) begin
                    state_d = S_EXEC;
                end else begin
`ifdef MC_ILLEGAL_TRAP_EN
                    if (Instruction != 32'h0000_0000) begin
                        state_d = S_HALT;
                    end else begin
                        ctrl.pc_write = 1'b1;
                        state_d       = S_FETCH;
                    end
`else
                    ctrl.pc_write = 1'b1;
                    state_d       = S_FETCH;
`endif
                end
            end
            S_EXEC: begin
                state_d = S_FETCH;
                if (is_alu_r) begin
                    ctrl.alu_ctrl = is_subu ? 3'b001 : 3'b000;
                    state_d       = S_WB;
                end else if (is_imm) begin
                    ctrl.alu_src  = 1'b1;
                    ctrl.alu_ctrl = is_lui ? 3'b011 : 3'b010;
                    state_d       = S_WB;
                end else if (is_load || is_store) begin
                    ctrl.alu_src = 1'b1;
                    ctrl.ext_op  = 1'b1;
                    state_d      = S_MEM;
                end else if (is_beq) begin
                    ctrl.alu_ctrl = 3'b001;
                    ctrl.npc_op   = 3'b001;
                    ctrl.pc_write = 1'b1;
                end else if (is_j || is_jal) begin
                    ctrl.npc_op    = 3'b010;
                    ctrl.pc_write  = 1'b1;
                    ctrl.jal_sel   = is_jal;
                    ctrl.reg_write = is_jal;
                end else if (is_jr) begin
                    ctrl.npc_op   = 3'b011;
                    ctrl.pc_write = 1'b1;
                end
            end
            S_MEM: begin
                state_d = S_FETCH;
                if (is_load) begin
                    // Address operands stay applied while the DM read settles.
                    ctrl.alu_src = 1'b1;
                    ctrl.ext_op  = 1'b1;
                    ctrl.lb_sel  = is_lb;
                    state_d      = S_WB;
                end else if (is_store) begin
                    ctrl.mem_write = 1'b1;
                    ctrl.pc_write  = 1'b1;
                    ctrl.sb_sel    = is_sb;
                end
            end
            S_WB: begin
                ctrl.pc_write = 1'b1;
                state_d       = S_FETCH;
                if (is_alu_r) begin
                    ctrl.reg_dst   = 1'b1;
                    ctrl.reg_write = 1'b1;
                end else if (is_imm) begin
                    ctrl.reg_write = 1'b1;
                    ctrl.alu_src   = 1'b1;
                    ctrl.alu_ctrl  = is_lui ? 3'b011 : 3'b010;
                end else if (is_load) begin
                    ctrl.mem_to_reg = 1'b1;
                    ctrl.reg_write  = 1'b1;
                    ctrl.lb_sel     = is_lb;
                end
            end
`ifdef MC_ILLEGAL_TRAP_EN
            S_HALT: begin
                state_d = S_HALT;
            end
`endif
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // Reset masks every strobe in the same cycle, so a half-finished instruction commits nothing.
    always_comb begin
        {PcWrite, IrWrite, Extop, ALUSrc, ALUControl, RegDst, RegWrite,
         MemtoReg, MemWrite, lb_sel, sb_sel, jal_sel, Npc_op} = reset ? '0 : ctrl;
        state_o = reset ? 3'd0 : state_q;
    end

endmodule
